immediate_inserter: RTL and testbench

Inverse of the core's immediate extractor: takes a base instruction word, a sign-extended immediate and a 2-bit format select, and writes the immediate into that format's instruction bit fields. Any instruction bit outside those fields is passed through unchanged. It checks that the immediate fits the selected format, flags and counts words that do not fit, and registers the result behind a valid/ready handshake with a skid buffer. It sits in the instruction-patching path (test-program generation, branch/jump relocation), upstream of instruction memory writes.

---
 rtl/immediate_inserter.sv | 150 +++++++++++++++
 tb/tb_immediate_inserter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/immediate_inserter.sv
// Writes a sign-extended immediate into the I/S/B/J fields of a base word and flags out-of-range values.
// One-cycle latency through a valid/ready output register backed by a single skid register; at most two words held.
module immediate_inserter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ImmSrc,
    input  logic [31:0]      Base,
    input  logic [31:0]      Imm,
    input  logic             InValid,
    output logic             InReady,
    output logic [31:0]      OutInstr,
    output logic             OutErr,
    output logic             OutValid,
    input  logic             OutReady,
    input  logic             ErrClr,
    output logic [CNT_W-1:0] ErrCount
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] field_mask;
    logic [31:0] field_bits;
    logic [31:0] patched;
    logic        range_err;
    logic        fits_12;
    logic        fits_20;

    logic             out_vld_q, out_vld_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic             out_err_q, out_err_d;
    logic             skid_vld_q, skid_vld_d;
    logic [31:0]      skid_instr_q, skid_instr_d;
    logic             skid_err_q, skid_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic accept;
    logic consume;

    // A value fits when every bit above the field's sign bit matches that sign bit.
    assign fits_12 = (&Imm[31:11]) | ~(|Imm[31:11]);
    assign fits_20 = (&Imm[31:19]) | ~(|Imm[31:19]);

    always_comb begin
        field_mask = 32'h0;
        field_bits = 32'h0;
        range_err  = 1'b0;
        case (ImmSrc)
            FMT_I: begin
                field_mask = 32'hFFF0_0000;
                field_bits = {Imm[11:0], 20'b0};
                range_err  = ~fits_12;
            end
            FMT_S: begin
                field_mask = 32'hFE00_0F80;
                field_bits = {Imm[11:5], 13'b0, Imm[4:0], 7'b0};
                range_err  = ~fits_12;
            end
            FMT_B: begin
                field_mask = 32'hFE00_0F80;
                field_bits = {Imm[11], Imm[9:4], 13'b0, Imm[3:0], Imm[10], 7'b0};
                range_err  = ~fits_12;
            end
            FMT_J: begin
                field_mask = 32'hFFFF_F000;
                field_bits = {Imm[19], Imm[9:0], Imm[10], Imm[18:11], 12'b0};
                range_err  = ~fits_20;
            end
            default: begin
                field_mask = 32'h0;
                field_bits = 32'h0;
                range_err  = 1'b0;
            end
        endcase
    end

    assign patched = (Base & ~field_mask) | field_bits;

    assign InReady = rst_n & ~skid_vld_q;
    assign accept  = InValid & InReady;
    assign consume = out_vld_q & OutReady;

    always_comb begin
        out_vld_d    = out_vld_q;
        out_instr_d  = out_instr_q;
        out_err_d    = out_err_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_err_d   = skid_err_q;

        if (consume && skid_vld_q) begin
            // InReady is low here, so no accept can collide with the skid drain.
            out_vld_d   = 1'b1;
            out_instr_d = skid_instr_q;
            out_err_d   = skid_err_q;
            skid_vld_d  = 1'b0;
        end else if (accept && (!out_vld_q || consume)) begin
            out_vld_d   = 1'b1;
            out_instr_d = patched;
            out_err_d   = range_err;
        end else if (accept) begin
            skid_vld_d   = 1'b1;
            skid_instr_d = patched;
            skid_err_d   = range_err;
        end else if (consume) begin
            out_vld_d = 1'b0;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ErrClr) begin
            err_cnt_d = '0;
        end else if (accept && range_err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q    <= 1'b0;
            out_instr_q  <= 32'h0;
            out_err_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_vld_q    <= out_vld_d;
            out_instr_q  <= out_instr_d;
            out_err_q    <= out_err_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign OutValid = out_vld_q;
    assign OutInstr = out_instr_q;
    assign OutErr   = out_err_q;
    assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_immediate_inserter.sv
// Directed-vector bench for immediate_inserter: field insertion, range flagging, skid buffering, counter, reset.
module tb_immediate_inserter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ImmSrc;
    logic [31:0] Base;
    logic [31:0] Imm;
    logic        InValid;
    logic        InReady;
    logic [31:0] OutInstr;
    logic        OutErr;
    logic        OutValid;
    logic        OutReady;
    logic        ErrClr;
    logic [7:0]  ErrCount;

    int n_vec;
    int n_err;

    immediate_inserter #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ImmSrc   (ImmSrc),
        .Base     (Base),
        .Imm      (Imm),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutInstr (OutInstr),
        .OutErr   (OutErr),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ErrClr   (ErrClr),
        .ErrCount (ErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one word for exactly one rising edge; returns at the following falling edge.
    task automatic drive_word(input logic [1:0] src, input logic [31:0] b, input logic [31:0] i);
        @(negedge clk);
        ImmSrc  = src;
        Base    = b;
        Imm     = i;
        InValid = 1'b1;
        @(negedge clk);
        InValid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset_outvalid got %b want 0", OutValid); end
        n_vec++; if (OutInstr !== 32'h0) begin n_err++; $display("FAIL reset_outinstr got %h want 00000000", OutInstr); end
        n_vec++; if (OutErr !== 1'b0) begin n_err++; $display("FAIL reset_outerr got %b want 0", OutErr); end
        n_vec++; if (ErrCount !== 8'd0) begin n_err++; $display("FAIL reset_errcount got %0d want 0", ErrCount); end
        n_vec++; if (InReady !== 1'b0) begin n_err++; $display("FAIL reset_inready_low got %b want 0", InReady); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL reset_inready_release got %b want 1", InReady); end
    endtask

    task automatic test_i_format;
        OutReady = 1'b1;
        drive_word(2'b00, 32'h0000_0513, 32'hFFFF_FFFF);
        n_vec++; if (OutValid !== 1'b1) begin n_err++; $display("FAIL i_valid got %b want 1", OutValid); end
        n_vec++; if (OutInstr !== 32'hFFF0_0513) begin n_err++; $display("FAIL i_instr got %h want fff00513", OutInstr); end
        n_vec++; if (OutErr !== 1'b0) begin n_err++; $display("FAIL i_err got %b want 0", OutErr); end
    endtask

    task automatic test_s_b_format;
        drive_word(2'b01, 32'h0000_2023, 32'h0000_07F5);
        n_vec++; if (OutInstr !== 32'h7E00_2AA3) begin n_err++; $display("FAIL s_instr got %h want 7e002aa3", OutInstr); end
        n_vec++; if (OutErr !== 1'b0) begin n_err++; $display("FAIL s_err got %b want 0", OutErr); end
        drive_word(2'b10, 32'h0000_0063, 32'hFFFF_F800);
        n_vec++; if (OutInstr !== 32'h8000_0063) begin n_err++; $display("FAIL b_instr got %h want 80000063", OutInstr); end
        n_vec++; if (OutErr !== 1'b0) begin n_err++; $display("FAIL b_err got %b want 0", OutErr); end
        // Upper base bits outside the B fields must survive.
        drive_word(2'b10, 32'h01FF_F07F, 32'h0000_0000);
        n_vec++; if (OutInstr !== 32'h01FF_F07F) begin n_err++; $display("FAIL b_passthru got %h want 01fff07f", OutInstr); end
    endtask

    task automatic test_j_and_range;
        drive_word(2'b11, 32'h0000_006F, 32'h0007_FFFF);
        n_vec++; if (OutInstr !== 32'h7FFF_F06F) begin n_err++; $display("FAIL j_max_instr got %h want 7ffff06f", OutInstr); end
        n_vec++; if (OutErr !== 1'b0) begin n_err++; $display("FAIL j_max_err got %b want 0", OutErr); end
        drive_word(2'b11, 32'h0000_006F, 32'hFFF8_0000);
        n_vec++; if (OutInstr !== 32'h8000_006F) begin n_err++; $display("FAIL j_min_instr got %h want 8000006f", OutInstr); end
        n_vec++; if (OutErr !== 1'b0) begin n_err++; $display("FAIL j_min_err got %b want 0", OutErr); end
        drive_word(2'b00, 32'h0000_0513, 32'h0000_0800);
        n_vec++; if (OutInstr !== 32'h8000_0513) begin n_err++; $display("FAIL i_range_instr got %h want 80000513", OutInstr); end
        n_vec++; if (OutErr !== 1'b1) begin n_err++; $display("FAIL i_range_err got %b want 1", OutErr); end
        n_vec++; if (ErrCount !== 8'd1) begin n_err++; $display("FAIL i_range_count got %0d want 1", ErrCount); end
        drive_word(2'b11, 32'h0000_006F, 32'h0008_0000);
        n_vec++; if (OutInstr !== 32'h8000_006F) begin n_err++; $display("FAIL j_range_instr got %h want 8000006f", OutInstr); end
        n_vec++; if (OutErr !== 1'b1) begin n_err++; $display("FAIL j_range_err got %b want 1", OutErr); end
        n_vec++; if (ErrCount !== 8'd2) begin n_err++; $display("FAIL j_range_count got %0d want 2", ErrCount); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        OutReady = 1'b0;
        ImmSrc   = 2'b00;
        Base     = 32'h0000_0013;
        Imm      = 32'd1;
        InValid  = 1'b1;
        n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL bp_ready_a got %b want 1", InReady); end
        @(negedge clk);
        Imm = 32'd2;
        n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL bp_ready_b got %b want 1", InReady); end
        n_vec++; if (OutInstr !== 32'h0010_0013) begin n_err++; $display("FAIL bp_out_a got %h want 00100013", OutInstr); end
        @(negedge clk);
        Imm = 32'd3;
        n_vec++; if (InReady !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b want 0", InReady); end
        @(negedge clk);
        n_vec++; if (InReady !== 1'b0) begin n_err++; $display("FAIL bp_ready_hold got %b want 0", InReady); end
        n_vec++; if (OutInstr !== 32'h0010_0013 || OutValid !== 1'b1) begin n_err++; $display("FAIL bp_stable got %h/%b want 00100013/1", OutInstr, OutValid); end
        OutReady = 1'b1;
        @(negedge clk);
        n_vec++; if (OutInstr !== 32'h0020_0013 || OutValid !== 1'b1) begin n_err++; $display("FAIL bp_out_b got %h/%b want 00200013/1", OutInstr, OutValid); end
        n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise got %b want 1", InReady); end
        @(negedge clk);
        InValid = 1'b0;
        n_vec++; if (OutInstr !== 32'h0030_0013 || OutValid !== 1'b1) begin n_err++; $display("FAIL bp_out_c got %h/%b want 00300013/1", OutInstr, OutValid); end
        @(negedge clk);
        n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", OutValid); end
    endtask

    task automatic test_counter;
        @(negedge clk);
        ErrClr = 1'b1;
        @(negedge clk);
        ErrClr = 1'b0;
        n_vec++; if (ErrCount !== 8'd0) begin n_err++; $display("FAIL cnt_clear got %0d want 0", ErrCount); end
        ImmSrc  = 2'b00;
        Base    = 32'h0000_0513;
        Imm     = 32'h0000_0800;
        InValid = 1'b1;
        repeat (100) @(negedge clk);
        n_vec++; if (ErrCount !== 8'd100) begin n_err++; $display("FAIL cnt_100 got %0d want 100", ErrCount); end
        repeat (200) @(negedge clk);
        InValid = 1'b0;
        n_vec++; if (ErrCount !== 8'd255) begin n_err++; $display("FAIL cnt_sat got %0d want 255", ErrCount); end
        repeat (3) @(negedge clk);
        n_vec++; if (ErrCount !== 8'd255) begin n_err++; $display("FAIL cnt_hold got %0d want 255", ErrCount); end
        InValid = 1'b1;
        ErrClr  = 1'b1;
        @(negedge clk);
        ErrClr = 1'b0;
        n_vec++; if (ErrCount !== 8'd0) begin n_err++; $display("FAIL cnt_clr_wins got %0d want 0", ErrCount); end
        n_vec++; if (OutErr !== 1'b1) begin n_err++; $display("FAIL cnt_outerr got %b want 1", OutErr); end
        @(negedge clk);
        InValid = 1'b0;
        n_vec++; if (ErrCount !== 8'd1) begin n_err++; $display("FAIL cnt_after_clr got %0d want 1", ErrCount); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        OutReady = 1'b0;
        ImmSrc   = 2'b00;
        Base     = 32'h0000_0093;
        Imm      = 32'h0000_0800;
        InValid  = 1'b1;
        repeat (2) @(negedge clk);
        InValid = 1'b0;
        n_vec++; if (InReady !== 1'b0 || OutValid !== 1'b1) begin n_err++; $display("FAIL rm_full got rdy=%b vld=%b want 0/1", InReady, OutValid); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL rm_outvalid got %b want 0", OutValid); end
        n_vec++; if (OutInstr !== 32'h0) begin n_err++; $display("FAIL rm_outinstr got %h want 00000000", OutInstr); end
        n_vec++; if (ErrCount !== 8'd0) begin n_err++; $display("FAIL rm_errcount got %0d want 0", ErrCount); end
        n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL rm_inready got %b want 1", InReady); end
        OutReady = 1'b1;
        drive_word(2'b00, 32'h0000_0513, 32'hFFFF_FFFF);
        n_vec++; if (OutInstr !== 32'hFFF0_0513 || OutValid !== 1'b1) begin n_err++; $display("FAIL rm_post got %h/%b want fff00513/1", OutInstr, OutValid); end
        @(negedge clk);
        n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL rm_no_dup got %b want 0", OutValid); end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        ImmSrc   = 2'b00;
        Base     = 32'h0;
        Imm      = 32'h0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        ErrClr   = 1'b0;
        test_reset();
        test_i_format();
        test_s_b_format();
        test_j_and_range();
        test_backpressure();
        test_counter();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
